mix_columns_seq: RTL

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/aes_pkg.sv | 16 +
 rtl/mix_column_unit.sv | 19 +
 rtl/mix_columns_seq.sv | 68 ++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, GF(2^8) helpers and the MixColumns FSM state type
package aes_pkg;
  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction
endpackage

// File: rtl/mix_column_unit.sv
// mix_column_unit: combinational forward/inverse MixColumns on one 32-bit column
module mix_column_unit import aes_pkg::*; #(
  parameter bit INV_EN = 1'b1
) (
  input  logic [COL_W-1:0] col,
  input  logic             inv,
  output logic [COL_W-1:0] res
);
  localparam logic [15:0] FWD_K = 16'h2311;
  localparam logic [15:0] INV_K = 16'hebd9;
  logic [15:0] k;
  assign k = (INV_EN && inv) ? INV_K : FWD_K;
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign res[31-8*r -: 8] = gf_mul(col[31:24], k[15-4*((4-r)%4) -: 4])
                            ^ gf_mul(col[23:16], k[15-4*((5-r)%4) -: 4])
                            ^ gf_mul(col[15:8],  k[15-4*((6-r)%4) -: 4])
                            ^ gf_mul(col[7:0],   k[15-4*((7-r)%4) -: 4]);
  end
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns/InvMixColumns, COLS_PER_CYCLE columns per clock
module mix_columns_seq import aes_pkg::*; #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);
  localparam int GW = COL_W * COLS_PER_CYCLE;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t state, nxt;
  logic [1:0] cnt;
  logic mode;
  logic [STATE_W-1:0] work;
  logic [6:0] hi;
  logic last;
  logic [GW-1:0] grp_in, grp_out;
  assign hi = 7'd127 - {cnt, 5'd0};
  assign last = cnt == 2'(4 - COLS_PER_CYCLE);
  assign grp_in = work[hi -: GW];
  assign out_data = work;
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    mix_column_unit #(.INV_EN(INV_EN)) u_col (
      .col(grp_in[GW-1-COL_W*i -: COL_W]),
      .inv(mode),
      .res(grp_out[GW-1-COL_W*i -: COL_W])
    );
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: accept in IDLE, walk column groups in BUSY, release on output handshake
  always_comb
    nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
          state == BUSY ? (last ? DONE : BUSY) :
          (out_ready ? IDLE : DONE);
  // handshake and status outputs decoded from state
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  // working register: capture on accept, transform the selected column group in place while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      work <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (in_ready && in_valid) begin
      work <= in_data;
      mode <= INV_EN && inv;
      cnt  <= '0;
    end else if (state == BUSY) begin
      work[hi -: GW] <= grp_out;
      cnt  <= cnt + 2'(COLS_PER_CYCLE);
    end
endmodule
